// File: rtl/line_mem_responder.sv
// Fixed-latency line memory: accepts one 128-bit read or write at a time and
// answers with a single-cycle mem_resp pulse LATENCY cycles after acceptance.
module line_mem_responder #(
    parameter int DEPTH_BITS = 5,
    parameter int LATENCY    = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_address,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_resp,
    output logic         busy
);

    localparam int         LINES = 1 << DEPTH_BITS;
    localparam logic [3:0] LOAD  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [3:0]             count;
    logic [3:0]             count_nxt;
    logic                   resp_nxt;
    logic                   busy_nxt;
    logic                   accept;
    logic                   perform;
    logic [DEPTH_BITS-1:0]  idx;
    logic                   op_write;
    logic [127:0]           wdata_lat;
    logic [127:0]           lines [LINES];
    logic                   unused_addr_bits;

    // Offset bits and aliasing upper bits never reach the array.
    assign unused_addr_bits = &{1'b0, mem_address[15:DEPTH_BITS+4], mem_address[3:0]};

    assign accept  = (state == IDLE) && (mem_read || mem_write);
    assign perform = (state == BUSY) && (count == 4'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= 4'd0;
            mem_resp <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            mem_resp <= resp_nxt;
            busy     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (count == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        count_nxt = count;
        if (accept) begin
            count_nxt = LOAD;
        end else if ((state == BUSY) && (count != 4'd0)) begin
            count_nxt = count - 4'd1;
        end
        resp_nxt = (state_nxt == RESP);
        busy_nxt = (state_nxt != IDLE);
    end

    // A simultaneous read and write collapses to a write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx      <= '0;
            op_write <= 1'b0;
        end else if (accept) begin
            idx      <= mem_address[DEPTH_BITS+3:4];
            op_write <= mem_write;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wdata_lat <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LINES; i++) begin
                lines[i] <= '0;
            end
        end else if (perform && op_write) begin
            lines[idx] <= wdata_lat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_rdata <= '0;
        end else if (perform && !op_write) begin
            mem_rdata <= lines[idx];
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: a LATENCY=4 instance driven from a
// vector table plus a LATENCY=1 instance for back-to-back request streaming.
module tb_line_mem_responder;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
        logic [127:0] exp_rdata;
    } vec_t;

    localparam logic [127:0] D1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] D2 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
    localparam logic [127:0] DA = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
    localparam logic [127:0] DB = 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;
    localparam logic [127:0] D3 = 128'hCAFE_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [127:0] D4 = 128'h0BAD_F00D_0BAD_F00D_0BAD_F00D_0BAD_F00D;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         mem_read = 1'b0, mem_write = 1'b0;
    logic [15:0]  mem_address = '0;
    logic [127:0] mem_wdata = '0;
    logic [127:0] mem_rdata;
    logic         mem_resp, busy;

    logic         read1 = 1'b0, write1 = 1'b0;
    logic [15:0]  address1 = '0;
    logic [127:0] wdata1 = '0;
    logic [127:0] rdata1;
    logic         resp1, busy1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    line_mem_responder #(.DEPTH_BITS(5), .LATENCY(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .busy(busy)
    );

    line_mem_responder #(.DEPTH_BITS(5), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .mem_read(read1), .mem_write(write1),
        .mem_address(address1), .mem_wdata(wdata1), .mem_rdata(rdata1),
        .mem_resp(resp1), .busy(busy1)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                                input logic [127:0] wdata, input logic [127:0] exp_rdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    // One transaction on the LATENCY=4 instance; inputs are scrambled while busy.
    task automatic do_txn(input vec_t v, input string name);
        int  lat;
        logic busy_ok;
        @(negedge clk);
        mem_read = v.rd; mem_write = v.wr; mem_address = v.addr; mem_wdata = v.wdata;
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b0; mem_address = 16'hAAA0; mem_wdata = ~v.wdata;
        lat = -1;
        busy_ok = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (mem_resp === 1'b1) begin
                lat = n;
                break;
            end
        end
        check({name, " latency"}, 128'(lat), 128'(4));
        check({name, " busy_in_flight"}, 128'(busy_ok), 128'(1));
        check({name, " rdata"}, mem_rdata, v.exp_rdata);
        @(negedge clk);
        check({name, " idle_after"}, {126'd0, busy, mem_resp}, 128'd0);
        check({name, " rdata_held"}, mem_rdata, v.exp_rdata);
    endtask

    vec_t vecs[14];

    initial begin
        int   lat;
        logic seen;
        vec_t v;

        vecs[0]  = mk(1'b1, 1'b0, 16'h0040, '0, '0);
        vecs[1]  = mk(1'b0, 1'b1, 16'h0050, D1, '0);
        vecs[2]  = mk(1'b1, 1'b0, 16'h0050, '0, D1);
        vecs[3]  = mk(1'b1, 1'b0, 16'h0040, '0, '0);
        vecs[4]  = mk(1'b0, 1'b1, 16'h0060, D2, '0);
        vecs[5]  = mk(1'b1, 1'b0, 16'h0260, '0, D2);
        vecs[6]  = mk(1'b1, 1'b0, 16'h0068, '0, D2);
        vecs[7]  = mk(1'b1, 1'b1, 16'h0070, DA, D2);
        vecs[8]  = mk(1'b1, 1'b0, 16'h0070, '0, DA);
        vecs[9]  = mk(1'b0, 1'b1, 16'h0070, DB, DA);
        vecs[10] = mk(1'b1, 1'b0, 16'h0070, '0, DB);
        vecs[11] = mk(1'b1, 1'b0, 16'hFFF0, '0, '0);
        vecs[12] = mk(1'b0, 1'b1, 16'hFFF0, D3, '0);
        vecs[13] = mk(1'b1, 1'b0, 16'h01F0, '0, D3);

        repeat (3) @(negedge clk);
        check("reset mem_resp", 128'(mem_resp), 128'd0);
        check("reset busy", 128'(busy), 128'd0);
        check("reset mem_rdata", mem_rdata, '0);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // LATENCY=1: one write, then a read held high streams transactions.
        @(negedge clk);
        write1 = 1'b1; address1 = 16'h0000; wdata1 = D1;
        @(posedge clk);
        #1;
        write1 = 1'b0;
        lat = -1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (resp1 === 1'b1) begin
                lat = n;
                break;
            end
        end
        check("lat1 write latency", 128'(lat), 128'(1));
        @(negedge clk);
        check("lat1 idle busy", 128'(busy1), 128'd0);
        read1 = 1'b1;
        @(posedge clk);
        for (int m = 0; m < 9; m++) begin
            @(negedge clk);
            check($sformatf("lat1 stream m%0d busy_resp", m), {126'd0, busy1, resp1},
                  {126'd0, (m % 3) != 2, (m % 3) == 1});
            if ((m % 3) == 1) check($sformatf("lat1 stream m%0d rdata", m), rdata1, D1);
        end
        read1 = 1'b0;
        repeat (4) @(negedge clk);

        // Reset aborts an in-flight write.
        @(negedge clk);
        mem_write = 1'b1; mem_address = 16'h0010; mem_wdata = D4;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort immediate busy_resp", {126'd0, busy, mem_resp}, 128'd0);
        check("abort immediate rdata", mem_rdata, '0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (mem_resp !== 1'b0) seen = 1'b1;
        end
        check("abort no resp", 128'(seen), 128'd0);
        v = mk(1'b1, 1'b0, 16'h0010, '0, '0);
        do_txn(v, "abort read 0x0010");
        v = mk(1'b1, 1'b0, 16'h0050, '0, '0);
        do_txn(v, "post-reset read 0x0050");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
